// File: rtl/key_sched_counter_pkg.sv
// Shared defaults, roll-mode encodings and counter-width helper for the key scheduler.
package key_sched_counter_pkg;

  localparam int ROLL_PULSE  = 0;
  localparam int ROLL_STICKY = 1;

  localparam int DEF_NUM_KEYS       = 4;
  localparam int DEF_BLOCKS_PER_KEY = 1;
  localparam int DEF_STICKY_ROLL    = ROLL_PULSE;

  // A counter over n states needs clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_sched_counter_flex_counter.sv
// Wrapping up-counter 0..TERMINAL, priority clear > load > enable; one-cycle latency.
// Never stalls. Load clamps to TERMINAL. wrap is a registered one-cycle pulse.
module flex_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 15
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_term,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

  assign at_term = (count == TERM);

  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > TERM) ? TERM : load_val;
    end else if (enable) begin
      if (at_term) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_d;
    end
  end

endmodule

// File: rtl/key_sched_counter.sv
// Key-slot scheduler: counts blocks per slot and slots per key ring; all outputs registered (1 cycle).
// No backpressure: every enabled cycle is consumed; rollover is a pulse or held until acked.
module key_sched_counter
  import key_sched_counter_pkg::*;
#(
  parameter int NUM_KEYS       = DEF_NUM_KEYS,
  parameter int BLOCKS_PER_KEY = DEF_BLOCKS_PER_KEY,
  parameter int STICKY_ROLL    = DEF_STICKY_ROLL
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  clear,
  input  logic                                  count_enable,
  input  logic                                  load_en,
  input  logic [cnt_width(NUM_KEYS)-1:0]        load_key,
  input  logic                                  rollover_ack,
  output logic [cnt_width(NUM_KEYS)-1:0]        key_count,
  output logic [cnt_width(BLOCKS_PER_KEY)-1:0]  block_count,
  output logic                                  key_advance,
  output logic                                  key_rollover
);

  localparam int KW = cnt_width(NUM_KEYS);
  localparam int BW = cnt_width(BLOCKS_PER_KEY);

  logic          blk_en;
  logic          blk_at_term;
  logic          key_en;
  logic          key_at_term;
  logic          key_wrap_q;
  logic          roll_hold;
  logic [BW-1:0] blk_zero;
  logic [KW-1:0] key_q;

  assign blk_zero = '0;
  assign blk_en   = count_enable & ~clear & ~load_en;
  // The key counter steps on the same edge the block counter wraps.
  assign key_en   = blk_en & blk_at_term;

  flex_counter #(
    .WIDTH    (BW),
    .TERMINAL (BLOCKS_PER_KEY - 1)
  ) u_blk_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .enable   (blk_en),
    .load     (load_en),
    .load_val (blk_zero),
    .count    (block_count),
    .at_term  (blk_at_term),
    .wrap     (key_advance)
  );

  flex_counter #(
    .WIDTH    (KW),
    .TERMINAL (NUM_KEYS - 1)
  ) u_key_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .enable   (key_en),
    .load     (load_en),
    .load_val (load_key),
    .count    (key_q),
    .at_term  (key_at_term),
    .wrap     (key_wrap_q)
  );

  assign key_count = key_q;

  // A new wrap beats a coincident ack so no rollover is ever lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      roll_hold <= 1'b0;
    end else if (clear) begin
      roll_hold <= 1'b0;
    end else begin
      roll_hold <= (key_en & key_at_term) | (roll_hold & ~rollover_ack);
    end
  end

  assign key_rollover = (STICKY_ROLL == ROLL_STICKY) ? roll_hold : key_wrap_q;

endmodule
